spi_command_controller: RTL and testbench

- Sequences host SPI traffic into the motion-segment FIFO, replacing the ad-hoc command FSM in the top level.
- Decodes the command byte, assembles complete motion-segment records in a staging buffer, and pushes a record into the FIFO only when it is whole and a slot is free.
- Sources the status byte returned on MISO.
- Sits between spi_secondary (byte side) and fifo (write side).

---
 rtl/spi_command_controller.sv | 213 +++++++++++++++++++++
 tb/tb_spi_command_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_controller.sv
// spi_command_controller
//   Turns host SPI traffic into motion-segment records for the segment FIFO.
//   The first byte of each chip-select window is a command. A write command
//   collects bytes into a staging buffer. A record is pushed into the FIFO
//   only when it is complete and a slot is free. A status command returns
//   the number of free record slots on MISO.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high reset
//   spi_cs           chip select, active low
//   rx_data/rx_valid byte from spi_secondary; rx_valid is a one-cycle strobe
//   tx_data          byte presented to spi_secondary for the next transfer
//   fifo_size        FIFO occupancy in words
//   fifo_write_en    FIFO write strobe
//   fifo_data        FIFO write data
//   records_written  records committed to the FIFO (wraps)
//   records_dropped  complete records dropped on a full FIFO (saturates)
//   partial_abort    one-cycle pulse when CS rises with a partial record staged
//   busy             high whenever the FSM is not in IDLE
//   dbg_state        current FSM state, for observation only
//
// Handshake: a byte is taken on any cycle where rx_valid is high and spi_cs
// is low. There is no back-pressure. The host must leave more than
// RecordWords+2 clk cycles between bytes so that a flush completes first.
// fifo_write_en has no ready: the FIFO must accept every write strobe.

module spi_command_controller #(
  parameter int WordSize    = 8,
  parameter int RecordWords = 8,
  parameter int Depth       = 16,
  parameter logic [WordSize-1:0] CmdWriteFifo = WordSize'(8'h01),
  parameter logic [WordSize-1:0] CmdStatus    = WordSize'(8'h02),
  localparam int SizeW = $clog2(Depth * RecordWords) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_cs,
  input  logic [WordSize-1:0] rx_data,
  input  logic                rx_valid,
  output logic [WordSize-1:0] tx_data,
  input  logic [SizeW-1:0]    fifo_size,
  output logic                fifo_write_en,
  output logic [WordSize-1:0] fifo_data,
  output logic [15:0]         records_written,
  output logic [7:0]          records_dropped,
  output logic                partial_abort,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int LogRW = $clog2(RecordWords);
  localparam int CntW  = LogRW + 1;
  localparam int IdxW  = (LogRW > 0) ? LogRW : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    STATUS  = 3'd2,
    WRITE   = 3'd3,
    FLUSH   = 3'd4,
    DISCARD = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]     count_q, count_d;
  logic [IdxW-1:0]     flush_idx_q, flush_idx_d;
  logic [15:0]         written_q, written_d;
  logic [7:0]          dropped_q, dropped_d;
  logic                overrun_q, overrun_d;
  logic [WordSize-1:0] tx_q, tx_d;
  logic                stage_we;
  logic [WordSize-1:0] staging_q [RecordWords];

  logic                byte_in;
  logic                rec_full;
  logic                flush_last;
  logic [SizeW-1:0]    used_slots;
  logic [7:0]          free_slots;

  assign byte_in    = rx_valid && !spi_cs;
  assign rec_full   = (count_q == CntW'(RecordWords));
  assign flush_last = (flush_idx_q == IdxW'(RecordWords - 1));
  assign used_slots = fifo_size >> LogRW;
  assign free_slots = 8'(Depth) - 8'(used_slots);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!spi_cs) state_d = CMD;
      CMD: begin
        if (spi_cs) state_d = IDLE;
        else if (rx_valid) begin
          if (rx_data == CmdStatus)         state_d = STATUS;
          else if (rx_data == CmdWriteFifo) state_d = WRITE;
          else                              state_d = DISCARD;
        end
      end
      STATUS:  if (spi_cs) state_d = IDLE;
      // A whole record is committed (or dropped) even if CS rises in the
      // same cycle. Only a partial record is abandoned.
      WRITE: begin
        if (rec_full) begin
          if (free_slots != 8'd0) state_d = FLUSH;
        end else if (spi_cs) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flush_last) begin
          if (spi_cs)                      state_d = IDLE;
          else if (overrun_q || byte_in)   state_d = DISCARD;
          else                             state_d = WRITE;
        end
      end
      DISCARD: if (spi_cs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    count_d     = count_q;
    flush_idx_d = flush_idx_q;
    written_d   = written_q;
    dropped_d   = dropped_q;
    overrun_d   = overrun_q;
    stage_we    = 1'b0;
    case (state_q)
      CMD: if (byte_in && rx_data == CmdWriteFifo) count_d = '0;
      WRITE: begin
        if (rec_full) begin
          count_d     = (free_slots == 8'd0) ? '0 : count_q;
          flush_idx_d = '0;
          if (free_slots == 8'd0 && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
        end else if (spi_cs) begin
          count_d = '0;
        end else if (rx_valid) begin
          stage_we = 1'b1;
          count_d  = count_q + CntW'(1);
        end
      end
      FLUSH: begin
        // A byte arriving mid-flush is lost; remember it so the rest of
        // the transaction is discarded rather than misaligned.
        if (byte_in) overrun_d = 1'b1;
        if (flush_last) begin
          count_d     = '0;
          flush_idx_d = '0;
          written_d   = written_q + 16'd1;
          overrun_d   = 1'b0;
        end else begin
          flush_idx_d = flush_idx_q + IdxW'(1);
        end
      end
      default: ;
    endcase
  end

  // tx_data is registered from the next state so that it powers up at 0
  // and then tracks free_slots in IDLE, CMD and STATUS.
  always_comb begin
    tx_d = '0;
    if (state_d == IDLE || state_d == CMD || state_d == STATUS)
      tx_d = WordSize'(free_slots);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      flush_idx_q <= '0;
      written_q   <= '0;
      dropped_q   <= '0;
      overrun_q   <= 1'b0;
      tx_q        <= '0;
    end else begin
      count_q     <= count_d;
      flush_idx_q <= flush_idx_d;
      written_q   <= written_d;
      dropped_q   <= dropped_d;
      overrun_q   <= overrun_d;
      tx_q        <= tx_d;
    end
  end

  // Staging buffer holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (stage_we) staging_q[count_q[IdxW-1:0]] <= rx_data;
  end

  // Outputs. They are decoded from state_q, so reset clears them
  // asynchronously.
  always_comb begin
    fifo_write_en = (state_q == FLUSH);
    fifo_data     = (state_q == FLUSH) ? staging_q[flush_idx_q] : '0;
    partial_abort = (state_q == WRITE) && spi_cs && !rec_full && (count_q != '0);
    busy          = (state_q != IDLE);
    dbg_state     = state_q;
  end

  assign tx_data         = tx_q;
  assign records_written = written_q;
  assign records_dropped = dropped_q;

endmodule

// File: tb/tb_spi_command_controller.sv
module tb_spi_command_controller;
  localparam int WS = 8;
  localparam int RW = 8;
  localparam int DP = 16;
  localparam int SW = $clog2(DP * RW) + 1;
  localparam logic [7:0] C_WR = 8'h01;
  localparam logic [7:0] C_ST = 8'h02;
  localparam int S_IDLE = 0, S_CMD = 1, S_STATUS = 2, S_WRITE = 3, S_DISCARD = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_cs;
  logic [WS-1:0] rx_data;
  logic          rx_valid;
  logic [WS-1:0] tx_data;
  logic [SW-1:0] fifo_size;
  logic          fifo_write_en;
  logic [WS-1:0] fifo_data;
  logic [15:0]   records_written;
  logic [7:0]    records_dropped;
  logic          partial_abort;
  logic          busy;
  logic [2:0]    dbg_state;

  spi_command_controller #(.WordSize(WS), .RecordWords(RW), .Depth(DP),
                           .CmdWriteFifo(C_WR), .CmdStatus(C_ST)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_data(tx_data), .fifo_size(fifo_size),
    .fifo_write_en(fifo_write_en), .fifo_data(fifo_data),
    .records_written(records_written), .records_dropped(records_dropped),
    .partial_abort(partial_abort), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [WS-1:0] exp_q[$];     // bytes expected on the FIFO write port
  logic [WS-1:0] stage_q[$];   // model of the bytes staged so far
  int  n_cmp = 0;
  int  n_fail = 0;
  int  exp_written = 0;
  int  exp_dropped = 0;
  int  exp_pa = 0;
  int  seen_pa = 0;
  bit  in_write = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected byte for every FIFO write strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_write_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fifo_write: unexpected write data %0h", fifo_data);
        end else begin
          logic [WS-1:0] e;
          e = exp_q.pop_front();
          if (fifo_data !== e) begin
            n_fail++;
            $display("FAIL fifo_data: got %0h expected %0h", fifo_data, e);
          end
        end
      end
      if (partial_abort) seen_pa++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int free_slots_model();
    return DP - int'(fifo_size) / RW;
  endfunction

  function automatic void model_byte(input logic [WS-1:0] b);
    if (!in_write) return;
    stage_q.push_back(b);
    if (stage_q.size() == RW) begin
      if (free_slots_model() > 0) begin
        foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
        exp_written = (exp_written + 1) % 65536;
      end else if (exp_dropped < 255) begin
        exp_dropped++;
      end
      stage_q.delete();
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_byte(input logic [WS-1:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [WS-1:0] b);
    pulse_byte(b);
    model_byte(b);
    repeat (RW + 4) tick();
  endtask

  task automatic send_cmd(input logic [WS-1:0] c);
    pulse_byte(c);
    in_write = (c == C_WR);
    stage_q.delete();
    repeat (2) tick();
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (2) tick();
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    if (in_write && stage_q.size() != 0) exp_pa++;
    in_write = 0;
    stage_q.delete();
    repeat (3) tick();
  endtask

  task automatic model_reset();
    exp_q.delete(); stage_q.delete();
    exp_written = 0; exp_dropped = 0; in_write = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int sel;
    reset = 1'b1; spi_cs = 1'b1; rx_valid = 1'b0; rx_data = '0; fifo_size = '0;
    repeat (3) tick();
    check("rst_write_en", fifo_write_en, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_partial_abort", partial_abort, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_written", records_written, 0);
    check("rst_dropped", records_dropped, 0);
    reset = 1'b0;
    tick();

    // Status read with an empty FIFO
    cs_low();
    check("status_cmd_state", dbg_state, S_CMD);
    check("status_cmd_tx", tx_data, 16);
    send_cmd(C_ST);
    check("status_state", dbg_state, S_STATUS);
    check("status_tx", tx_data, 16);
    pulse_byte(8'h5A);
    tick();
    check("status_ignores_rx", dbg_state, S_STATUS);
    cs_high();
    check("status_idle_busy", busy, 0);

    // Single record with latency measurement
    cs_low();
    send_cmd(C_WR);
    for (int i = 0; i < RW - 1; i++) send_byte(WS'(8'h11 + i));
    pulse_byte(8'h18);
    model_byte(8'h18);
    check("lat_count_cycle", fifo_write_en, 0);
    tick();
    check("lat_first_write", fifo_write_en, 1);
    n = 1;
    while (fifo_write_en && n < 3 * RW) begin
      tick();
      if (fifo_write_en) n++;
    end
    check("flush_length", n, RW);
    repeat (3) tick();
    check("single_written", records_written, 1);
    cs_high();

    // Full FIFO drops, then a record fits
    fifo_size = SW'(128);
    cs_low();
    send_cmd(C_WR);
    for (int i = 0; i < RW; i++) send_byte(WS'(8'h30 + i));
    check("full_dropped", records_dropped, 1);
    fifo_size = SW'(120);
    for (int i = 0; i < RW; i++) send_byte(WS'(8'h40 + i));
    check("after_full_written", records_written, 2);
    cs_high();

    // Partial abort, then a clean record
    fifo_size = '0;
    cs_low();
    send_cmd(C_WR);
    for (int i = 0; i < 3; i++) send_byte(WS'(8'hA0 + i));
    cs_high();
    check("partial_abort_pulses", seen_pa, exp_pa);
    check("partial_state", dbg_state, S_IDLE);
    cs_low();
    send_cmd(C_WR);
    for (int i = 0; i < RW; i++) send_byte(WS'(8'hB0 + i));
    cs_high();
    check("clean_after_abort", records_written, 3);

    // Unknown command
    cs_low();
    send_cmd(8'hEE);
    for (int i = 0; i < 10; i++) send_byte(WS'($urandom_range(0, 255)));
    check("discard_state", dbg_state, S_DISCARD);
    check("discard_tx", tx_data, 0);
    cs_high();
    check("discard_idle", dbg_state, S_IDLE);

    // Randomised transactions
    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 9);
      fifo_size = ($urandom_range(0, 3) == 0) ? SW'(128) : SW'($urandom_range(0, 127));
      cs_low();
      if (sel < 2) begin
        send_cmd(C_ST);
        check("rnd_status_tx", tx_data, free_slots_model());
      end else if (sel == 2) begin
        send_cmd(8'hC3);
        for (int i = 0; i < 3; i++) send_byte(WS'($urandom_range(0, 255)));
        check("rnd_discard_tx", tx_data, 0);
      end else begin
        send_cmd(C_WR);
        n = $urandom_range(0, 3 * RW + 2);
        for (int i = 0; i < n; i++) send_byte(WS'($urandom_range(0, 255)));
      end
      cs_high();
    end
    check("rnd_written", records_written, exp_written);
    check("rnd_dropped", records_dropped, exp_dropped);
    check("rnd_partial_abort", seen_pa, exp_pa);
    check("rnd_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a flush
    fifo_size = '0;
    cs_low();
    send_cmd(C_WR);
    for (int i = 0; i < RW - 1; i++) send_byte(WS'($urandom_range(0, 255)));
    pulse_byte(8'h77);
    model_byte(8'h77);
    n = 0;
    while (!fifo_write_en && n < 10) begin
      tick();
      n++;
    end
    check("pre_reset_flush_seen", fifo_write_en, 1);
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    check("mid_flush_write_en", fifo_write_en, 0);
    check("mid_flush_data", fifo_data, 0);
    check("mid_flush_state", dbg_state, S_IDLE);
    check("mid_flush_written", records_written, 0);
    check("mid_flush_dropped", records_dropped, 0);
    check("mid_flush_busy", busy, 0);
    model_reset();
    spi_cs = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("post_reset_no_writes", exp_q.size(), 0);
    check("post_reset_tx", tx_data, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
